// File: rtl/noc_inject_arb_if.sv
// Signal bundle between the local requesters / network send port and noc_inject_arb.
// Handshake: requester i holds req_valid[i] with its flit; the flit is taken in any cycle where req_valid[i] && req_ready[i].
interface noc_inject_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int FLIT_W  = 71,
  parameter int CW      = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*FLIT_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_ready;
  logic [FLIT_W-1:0]         put_flit;
  logic [1:0]                credit_in;
  logic [CW-1:0]             credits_vc0;
  logic [CW-1:0]             credits_vc1;
  logic                      busy;
  logic [2:0]                lock_id;
  logic                      err_credit;
  logic                      dbg_state;

  modport master (
    input  req_valid, req_flit, credit_in,
    output req_ready, put_flit, credits_vc0, credits_vc1, busy, lock_id, err_credit, dbg_state
  );

  modport slave (
    output req_valid, req_flit, credit_in,
    input  req_ready, put_flit, credits_vc0, credits_vc1, busy, lock_id, err_credit, dbg_state
  );
endinterface

// File: rtl/noc_inject_arb.sv
// Round-robin injection arbiter with wormhole packet lock and per-VC credit tracking
// in front of one network send port.
module noc_inject_arb #(
  parameter int NUM_REQ   = 4,
  parameter int BUF_DEPTH = 4,
  parameter int FLIT_W    = 71
) (
  input  logic              CLK,
  input  logic              RST,
  noc_inject_arb_if.master  bus
);
  localparam int CW = 4;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [2:0]        rr_ptr, rr_ptr_nxt;
  logic [2:0]        lock_id, lock_id_nxt;
  logic              lock_vc, lock_vc_nxt;
  logic [CW-1:0]     cred0, cred0_nxt, cred1, cred1_nxt;
  logic              ovf0, ovf1;
  logic [FLIT_W-1:0] put_q;
  logic              err_q;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] ready;
  logic               xfer;
  logic [2:0]         win;
  logic [FLIT_W-2:0]  win_body;  // bit 70 of an incoming flit carries no meaning
  logic               vc_used;
  logic               dec0, dec1, inc0, inc1;

  function automatic logic [2:0] wrap_inc(input logic [2:0] x);
    return (int'(x) == NUM_REQ - 1) ? 3'd0 : x + 3'd1;
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = bus.req_valid[i] &&
                (bus.req_flit[i*FLIT_W + 64] ? (cred1 != '0) : (cred0 != '0));
    end
  end

  // Winner selection; the search walks downward so the lowest offset from rr_ptr wins.
  always_comb begin
    win  = '0;
    xfer = 1'b0;
    if (!RST) begin
      if (state == LOCKED) begin
        win  = lock_id;
        xfer = bus.req_valid[lock_id] && (lock_vc ? (cred1 != '0) : (cred0 != '0));
      end else begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (elig[(int'(rr_ptr) + k) % NUM_REQ]) begin
            win  = 3'((int'(rr_ptr) + k) % NUM_REQ);
            xfer = 1'b1;
          end
        end
      end
    end
    win_body = bus.req_flit[int'(win)*FLIT_W +: FLIT_W-1];
    vc_used  = (state == LOCKED) ? lock_vc : win_body[64];
    ready    = xfer ? (NUM_REQ'(1) << win) : '0;
  end

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_id_nxt = lock_id;
    lock_vc_nxt = lock_vc;
    if (xfer) begin
      case (state)
        IDLE: begin
          if (win_body[69]) begin
            rr_ptr_nxt = wrap_inc(win);
          end else begin
            state_nxt   = LOCKED;
            lock_id_nxt = win;
            lock_vc_nxt = win_body[64];
          end
        end
        LOCKED: begin
          if (win_body[69]) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(lock_id);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A send and a return on the same VC in one cycle cancel out.
  always_comb begin
    dec0      = xfer && !vc_used;
    dec1      = xfer && vc_used;
    inc0      = bus.credit_in[1] && !bus.credit_in[0];
    inc1      = bus.credit_in[1] && bus.credit_in[0];
    cred0_nxt = cred0;
    cred1_nxt = cred1;
    ovf0      = 1'b0;
    ovf1      = 1'b0;
    if (inc0 && !dec0) begin
      if (cred0 == CW'(BUF_DEPTH)) ovf0 = 1'b1;
      else                         cred0_nxt = cred0 + 1'b1;
    end else if (dec0 && !inc0) begin
      cred0_nxt = cred0 - 1'b1;
    end
    if (inc1 && !dec1) begin
      if (cred1 == CW'(BUF_DEPTH)) ovf1 = 1'b1;
      else                         cred1_nxt = cred1 + 1'b1;
    end else if (dec1 && !inc1) begin
      cred1_nxt = cred1 - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
      lock_vc <= 1'b0;
      cred0   <= CW'(BUF_DEPTH);
      cred1   <= CW'(BUF_DEPTH);
      put_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      lock_id <= lock_id_nxt;
      lock_vc <= lock_vc_nxt;
      cred0   <= cred0_nxt;
      cred1   <= cred1_nxt;
      put_q   <= xfer ? {1'b1, win_body[69:65], vc_used, win_body[63:0]} : '0;
      err_q   <= err_q | ovf0 | ovf1;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.put_flit    = put_q;
  assign bus.credits_vc0 = cred0;
  assign bus.credits_vc1 = cred1;
  assign bus.busy        = (state == LOCKED);
  assign bus.lock_id     = lock_id;
  assign bus.err_credit  = err_q;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_noc_inject_arb.sv
// Bench for noc_inject_arb: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a behavioural model of grants, credits, lock and output flits.
module tb_noc_inject_arb;
  localparam int NUM_REQ   = 4;
  localparam int BUF_DEPTH = 4;
  localparam int FLIT_W    = 71;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  noc_inject_arb_if #(.NUM_REQ(NUM_REQ), .FLIT_W(FLIT_W), .CW(4)) bus ();

  noc_inject_arb #(.NUM_REQ(NUM_REQ), .BUF_DEPTH(BUF_DEPTH), .FLIT_W(FLIT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  logic [FLIT_W-1:0] cur_flit [NUM_REQ];
  int  pk_len [NUM_REQ];
  int  pk_idx [NUM_REQ];
  bit  auto_gen;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) bus.req_flit[i*FLIT_W +: FLIT_W] = cur_flit[i];
  end

  int tests;
  int fails;
  logic [FLIT_W-1:0] exp_q [$];
  int win_log [$];

  // Reference model state
  bit m_locked;
  int m_owner, m_ptr, m_vc;
  int m_cred [2];
  bit m_err;
  int owed [2];

  task automatic check(input string tag, input logic [FLIT_W-1:0] got, input logic [FLIT_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk_flit(input logic tail, input logic vc);
    return {1'($urandom), tail, 4'($urandom), vc, $urandom, $urandom};
  endfunction

  task automatic gen_next(input int i);
    pk_idx[i]++;
    if (pk_idx[i] >= pk_len[i]) begin
      pk_len[i] = $urandom_range(1, 4);
      pk_idx[i] = 0;
    end
    cur_flit[i] = mk_flit(pk_idx[i] == pk_len[i] - 1, 1'($urandom_range(0, 1)));
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_vc = 0;
    m_cred[0] = BUF_DEPTH; m_cred[1] = BUF_DEPTH;
    m_err = 0; owed[0] = 0; owed[1] = 0;
  endtask

  // Called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic tick();
    int ew, dw, vcu, c;
    bit d, r;
    logic [FLIT_W-1:0] f, ep;
    logic [NUM_REQ-1:0] er;
    #1;
    ew = -1;
    if (!RST) begin
      if (m_locked) begin
        if (bus.req_valid[m_owner] && m_cred[m_vc] > 0) ew = m_owner;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          c = (m_ptr + k) % NUM_REQ;
          if (ew < 0 && bus.req_valid[c] && m_cred[cur_flit[c][64]] > 0) ew = c;
        end
      end
    end
    er = (ew >= 0) ? (NUM_REQ'(1) << ew) : '0;
    dw = -1;
    for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) dw = i;
    win_log.push_back(dw);
    ep = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("req_ready",   FLIT_W'(bus.req_ready),   FLIT_W'(er));
    check("put_flit",    bus.put_flit,             ep);
    check("credits_vc0", FLIT_W'(bus.credits_vc0), FLIT_W'(m_cred[0]));
    check("credits_vc1", FLIT_W'(bus.credits_vc1), FLIT_W'(m_cred[1]));
    check("busy",        FLIT_W'(bus.busy),        FLIT_W'(m_locked));
    check("lock_id",     FLIT_W'(bus.lock_id),     FLIT_W'(m_owner));
    check("err_credit",  FLIT_W'(bus.err_credit),  FLIT_W'(m_err));
    vcu = -1;
    if (RST) begin
      model_reset();
    end else begin
      if (ew >= 0) begin
        f   = cur_flit[ew];
        vcu = m_locked ? m_vc : int'(f[64]);
        exp_q.push_back({1'b1, f[69:65], 1'(vcu), f[63:0]});
        if (m_locked) begin
          if (f[69]) begin m_locked = 0; m_ptr = (m_owner + 1) % NUM_REQ; end
        end else if (f[69]) begin
          m_ptr = (ew + 1) % NUM_REQ;
        end else begin
          m_locked = 1; m_owner = ew; m_vc = int'(f[64]);
        end
        owed[vcu]++;
      end
      for (int v = 0; v < 2; v++) begin
        d = (vcu == v);
        r = bus.credit_in[1] && (int'(bus.credit_in[0]) == v);
        if (r && !d) begin
          if (m_cred[v] == BUF_DEPTH) m_err = 1;
          else m_cred[v]++;
        end else if (d && !r) begin
          m_cred[v]--;
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    if (auto_gen && ew >= 0) gen_next(ew);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.credit_in = 2'b00;
    tick();
    RST = 1'b0;
  endtask

  task automatic drive_random();
    int v;
    for (int i = 0; i < NUM_REQ; i++) bus.req_valid[i] = ($urandom_range(0, 3) != 0);
    bus.credit_in = 2'b00;
    if ($urandom_range(0, 2) != 0) begin
      v = $urandom_range(0, 1);
      if (owed[v] > 0) begin
        bus.credit_in = {1'b1, 1'(v)};
        owed[v]--;
      end
    end
    RST = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    int base, n1, cnt;
    tests = 0; fails = 0; auto_gen = 0;
    model_reset();
    bus.req_valid = '1;
    bus.credit_in = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) cur_flit[i] = mk_flit(1'b1, 1'b0);

    // Reset held with every requester valid
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 3; k++) tick();
    RST = 1'b0;

    // Round-robin over single-flit vc0 packets, credits returned two cycles after use
    base = win_log.size();
    for (int k = 0; k < 8; k++) begin
      bus.credit_in = (k >= 2 && win_log[base + k - 2] >= 0) ? 2'b10 : 2'b00;
      tick();
    end
    for (int k = 0; k < 5; k++) check("rr_order", FLIT_W'(win_log[base + k]), FLIT_W'(k % NUM_REQ));

    // Wormhole lock: requester 1 sends 3 flits on vc1 while requester 2 waits
    do_reset();
    bus.req_valid = 4'b0110;
    cur_flit[1] = mk_flit(1'b0, 1'b1);
    cur_flit[2] = mk_flit(1'b1, 1'b0);
    n1 = 0;
    base = win_log.size();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (win_log[win_log.size() - 1] == 1) begin
        n1++;
        cur_flit[1] = mk_flit(n1 == 2, 1'b0);
        if (n1 == 3) bus.req_valid[1] = 1'b0;
      end
      if (win_log[win_log.size() - 1] == 2) bus.req_valid[2] = 1'b0;
    end
    check("worm_0", FLIT_W'(win_log[base]),     FLIT_W'(1));
    check("worm_1", FLIT_W'(win_log[base + 1]), FLIT_W'(1));
    check("worm_2", FLIT_W'(win_log[base + 2]), FLIT_W'(1));
    check("worm_3", FLIT_W'(win_log[base + 3]), FLIT_W'(2));

    // Credit exhaustion on vc0, then a single credit return
    do_reset();
    bus.req_valid = 4'b0001;
    cur_flit[0] = mk_flit(1'b1, 1'b0);
    base = win_log.size();
    for (int k = 0; k < 6; k++) tick();
    cnt = 0;
    for (int k = 0; k < 6; k++) if (win_log[base + k] == 0) cnt++;
    check("exhaust_cnt", FLIT_W'(cnt), FLIT_W'(4));
    check("exhaust_cred", FLIT_W'(bus.credits_vc0), FLIT_W'(0));
    bus.credit_in = 2'b10;
    tick();
    bus.credit_in = 2'b00;
    tick();
    check("credit_stall", FLIT_W'(win_log[win_log.size() - 2]), FLIT_W'(-1));
    check("credit_resume", FLIT_W'(win_log[win_log.size() - 1]), FLIT_W'(0));

    // vc0 starved: requester 3 on vc1 bypasses requester 0
    bus.req_valid = 4'b1001;
    cur_flit[3] = mk_flit(1'b1, 1'b1);
    tick();
    check("vc_bypass", FLIT_W'(win_log[win_log.size() - 1]), FLIT_W'(3));
    bus.credit_in = 2'b11;
    tick();
    bus.credit_in = 2'b00;
    bus.req_valid = '0;
    tick();
    check("vc1_simul", FLIT_W'(bus.credits_vc1), FLIT_W'(3));

    // Credit overflow, then reset in the middle of a locked packet
    do_reset();
    bus.credit_in = 2'b11;
    tick();
    bus.credit_in = 2'b00;
    tick();
    check("ovf_err", FLIT_W'(bus.err_credit), FLIT_W'(1));
    check("ovf_cred", FLIT_W'(bus.credits_vc1), FLIT_W'(BUF_DEPTH));
    bus.req_valid = 4'b0100;
    cur_flit[2] = mk_flit(1'b0, 1'b0);
    tick();
    tick();
    check("mid_busy", FLIT_W'(bus.busy), FLIT_W'(1));
    bus.req_valid = 4'b1001;
    cur_flit[0] = mk_flit(1'b1, 1'b0);
    cur_flit[3] = mk_flit(1'b1, 1'b1);
    do_reset();
    check("rst_busy", FLIT_W'(bus.busy), FLIT_W'(0));
    tick();
    check("rst_ptr", FLIT_W'(win_log[win_log.size() - 1]), FLIT_W'(0));

    // Randomized packets, credit returns and occasional resets
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      pk_len[i] = $urandom_range(1, 4);
      pk_idx[i] = 0;
      cur_flit[i] = mk_flit(pk_len[i] == 1, 1'($urandom_range(0, 1)));
    end
    auto_gen = 1;
    for (int k = 0; k < 3000; k++) begin
      drive_random();
      tick();
    end
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
